axi4_stream_to_axi4: RTL and testbench
======================================

# axi4_stream_to_axi4

Write-side counterpart of the frame buffer's memory-to-stream reader. Accepts one AXI4-Stream packet per arm strobe, stages it through an internal single-burst buffer, and writes it to memory as AXI4 INCR write bursts of at most BURST_LEN beats. On completion it reports the packet byte count and base address, in the same format the read-side block takes as its size/address inputs.

## Interface
- DATA_WIDTH, 64: stream and AXI data width, bits; DATA_WIDTH_B = DATA_WIDTH/8.
- ADDR_WIDTH, 32: AXI address width.
- ID_WIDTH / AWUSER_WIDTH / WUSER_WIDTH / ARUSER_WIDTH, 1: AXI sideband widths; all driven 0.
- BURST_LEN, 16: max beats per write burst, power of two, 1..256; also the internal buffer depth.
- MAX_PKT_SIZE_B, 2048: max accepted packet bytes.
- MAX_PKT_SIZE_WIDTH, $clog2(MAX_PKT_SIZE_B*4): width of the size output.
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- addr_i  input  ADDR_WIDTH  packet base address, sampled with wr_stb_i; low $clog2(DATA_WIDTH_B) bits forced to 0; caller aligns to BURST_LEN*DATA_WIDTH_B.
- wr_stb_i  input  1  arm for one packet; honoured only in IDLE_S.
- busy_o  output  1  high in every state except IDLE_S.
- pkt_done_o  output  1  one-cycle pulse after final B response.
- pkt_size_o  output  MAX_PKT_SIZE_WIDTH  bytes written; valid from pkt_done_o until next wr_stb_i.
- pkt_addr_o  output  ADDR_WIDTH  aligned base address of the packet.
- pkt_oversize_o  output  1  packet exceeded MAX_PKT_SIZE_B; valid with pkt_size_o.
- pkt_i  axi4_stream_if.slave  input stream; tdata, tkeep, tlast, tvalid used; tready driven.
- mem_o  axi4_if.master  memory; write channels used; AR tied off (arvalid 0), rready 1.

## Operation
- States: IDLE_S, FILL_S, AW_S, W_S, B_S.
- IDLE_S: tready 0. wr_stb_i -> latch aligned address into cur_addr and pkt_addr_o, clear beat counter, pkt_size_o and oversize; go to FILL_S.
- FILL_S: tready = 1 while buf_cnt < BURST_LEN. Each handshake writes {tdata, tkeep} to the buffer and increments buf_cnt. Exit to AW_S when buf_cnt reaches BURST_LEN or a tlast beat is accepted, whichever comes first.
- AW_S: awaddr = cur_addr, awlen = buf_cnt-1, awsize = $clog2(DATA_WIDTH_B), awburst INCR, awid/awcache/awprot/awqos/awregion/awlock 0. Leave on AW handshake.
- W_S: stream buffer out in order. wlast on beat buf_cnt. Leave after the wlast handshake.
- B_S: bready 1. bresp is ignored. On bvalid: cur_addr += buf_cnt*DATA_WIDTH_B and buf_cnt cleared. Go to IDLE_S with pkt_done_o if tlast was taken, otherwise back to FILL_S.
- Size: pkt_size_o = (beats-1)*DATA_WIDTH_B + popcount(tkeep of tlast beat).
- Oversize: once MAX_PKT_SIZE_B/DATA_WIDTH_B beats are stored, further beats are still accepted (tready 1) but not buffered, up to and including tlast. Set pkt_oversize_o; pkt_size_o saturates at MAX_PKT_SIZE_B.
- A packet of exactly k*BURST_LEN beats produces exactly k bursts, never a zero-length burst.
- tvalid with no tlast never times out. The block waits indefinitely.

## Timing
- Reset values: tready 0, awvalid 0, wvalid 0, wlast 0, bready 0, awaddr 0, awlen 0, busy_o 0, pkt_done_o 0, pkt_size_o 0, pkt_addr_o 0, pkt_oversize_o 0.
- Reset asserted mid-transfer: all of the above immediately, state IDLE_S, buffer contents discarded. No completion of an outstanding AXI transaction is attempted.
- wr_stb_i in cycle N -> tready may rise in N+1.
- Exit handshake in FILL_S at cycle N -> awvalid registered high in N+1. awvalid stays high until awready.
- AW handshake at N -> wvalid high in N+1. One beat per cycle while wready is held high; wvalid/wdata stable under backpressure.
- Final bvalid&bready at N -> pkt_done_o high in N+1. busy_o low in N+1. wr_stb_i accepted from N+1.
- tready is 0 in AW_S, W_S and B_S; there is no overlap of fill and drain.

## Configuration
- AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN defined: wstrb = stored tkeep of each beat, so partial last beats leave unkept bytes untouched in memory.
- Undefined: wstrb all ones on every beat; tkeep is not stored in the buffer and is used only for pkt_size_o.

## Test plan
All cases use DATA_WIDTH 64, BURST_LEN 16, MAX_PKT_SIZE_B 2048.
- 10 beats, last tkeep 0x0F, addr_i 0x1003 -> one burst: awaddr 0x1000, awlen 9, wlast on beat 10. pkt_size_o 76, pkt_addr_o 0x1000, single done pulse.
- 40 beats, full tkeep -> three bursts: awaddr 0x1000/0x1080/0x1100, awlen 15/15/7. pkt_size_o 320.
- 16 beats exactly -> one burst with awlen 15 and no second AW. Done one cycle after bvalid.
- awready delayed 5 cycles, wready toggling every cycle, bvalid delayed 3 cycles -> data order and wlast position preserved. tready 0 throughout AW_S/W_S/B_S.
- Macro on, last tkeep 0x03 -> last wstrb 0x03, others 0xFF. Macro off -> all wstrb 0xFF. pkt_size_o identical in both builds.
- 300-beat packet -> 256 beats written in 16 bursts, pkt_size_o 2048, pkt_oversize_o 1. Then reset asserted mid-W_S on the next packet -> outputs at reset values. A following 10-beat packet completes correctly.

Source files
------------

// File: rtl/axi4_stream_to_axi4_if.sv
// rtl/axi4_stream_to_axi4_if.sv - AXI4-Stream and AXI4 interface bundles used by axi4_stream_to_axi4
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

interface axi4_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH  = 1,
  parameter int ARUSER_WIDTH = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [STRB_WIDTH-1:0]   wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_stream_to_axi4.sv
// rtl/axi4_stream_to_axi4.sv - stream packet to AXI4 INCR write bursts; optional AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
module axi4_stream_to_axi4 #(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int BURST_LEN          = 16,
  parameter int MAX_PKT_SIZE_B     = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B * 4)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          wr_stb_i,
  output logic                          busy_o,
  output logic                          pkt_done_o,
  output logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_o,
  output logic [ADDR_WIDTH-1:0]         pkt_addr_o,
  output logic                          pkt_oversize_o,
  axi4_stream_if.slave                  pkt_i,
  axi4_if.master                        mem_o
);
  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
  localparam int CNT_W        = $clog2(BURST_LEN + 1);
  localparam int PTR_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int MAX_BEATS    = MAX_PKT_SIZE_B / DATA_WIDTH_B;
  localparam int BEAT_W       = $clog2(MAX_BEATS + 1);
  localparam int KEEP_CNT_W   = $clog2(DATA_WIDTH_B + 1);

  typedef enum logic [2:0] {IDLE_S, FILL_S, AW_S, W_S, B_S} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              buf_cnt;
  logic [CNT_W-1:0]              rd_cnt;
  logic [BEAT_W-1:0]             beat_cnt;
  logic [ADDR_WIDTH-1:0]         cur_addr;
  logic                          got_last;
  logic [DATA_WIDTH-1:0]         data_mem [BURST_LEN];
`ifdef AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
  logic [DATA_WIDTH_B-1:0]       keep_mem [BURST_LEN];
`endif
  logic                          t_hs;
  logic                          store_beat;
  logic [CNT_W-1:0]              buf_cnt_nxt;
  logic [KEEP_CNT_W-1:0]         keep_cnt;
  logic [MAX_PKT_SIZE_WIDTH-1:0] last_size;
  logic                          unused_inputs;

  assign pkt_i.tready = (state == FILL_S) && (buf_cnt < CNT_W'(BURST_LEN));
  assign busy_o       = (state != IDLE_S);
  assign t_hs         = pkt_i.tvalid && pkt_i.tready;
  // Beats past the size limit are drained from the stream but never stored.
  assign store_beat   = t_hs && (beat_cnt < BEAT_W'(MAX_BEATS));
  assign buf_cnt_nxt  = buf_cnt + CNT_W'(store_beat);
  assign last_size    = MAX_PKT_SIZE_WIDTH'(beat_cnt) * MAX_PKT_SIZE_WIDTH'(DATA_WIDTH_B)
                      + MAX_PKT_SIZE_WIDTH'(keep_cnt);

  assign mem_o.awid     = '0;
  assign mem_o.awsize   = 3'($clog2(DATA_WIDTH_B));
  assign mem_o.awburst  = 2'b01;
  assign mem_o.awlock   = 1'b0;
  assign mem_o.awcache  = '0;
  assign mem_o.awprot   = '0;
  assign mem_o.awqos    = '0;
  assign mem_o.awregion = '0;
  assign mem_o.awuser   = '0;
  assign mem_o.wuser    = '0;
  assign mem_o.arid     = '0;
  assign mem_o.araddr   = '0;
  assign mem_o.arlen    = '0;
  assign mem_o.arsize   = '0;
  assign mem_o.arburst  = '0;
  assign mem_o.arlock   = 1'b0;
  assign mem_o.arcache  = '0;
  assign mem_o.arprot   = '0;
  assign mem_o.arqos    = '0;
  assign mem_o.arregion = '0;
  assign mem_o.aruser   = '0;
  assign mem_o.arvalid  = 1'b0;
  assign mem_o.rready   = 1'b1;

  assign unused_inputs = ^{mem_o.bid, mem_o.bresp, mem_o.arready, mem_o.rid,
                           mem_o.rdata, mem_o.rresp, mem_o.rlast, mem_o.rvalid};

  // Byte count of the current beat, used only when it carries tlast.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DATA_WIDTH_B; i++) begin
      keep_cnt = keep_cnt + KEEP_CNT_W'(pkt_i.tkeep[i]);
    end
  end

  // Burst staging buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (store_beat) begin
      data_mem[buf_cnt[PTR_W-1:0]] <= pkt_i.tdata;
`ifdef AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
      keep_mem[buf_cnt[PTR_W-1:0]] <= pkt_i.tkeep;
`endif
    end
  end

  // Control FSM: fill one burst, issue AW, drain W, wait for B, repeat until tlast.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE_S;
      buf_cnt        <= '0;
      rd_cnt         <= '0;
      beat_cnt       <= '0;
      cur_addr       <= '0;
      got_last       <= 1'b0;
      mem_o.awvalid  <= 1'b0;
      mem_o.awaddr   <= '0;
      mem_o.awlen    <= '0;
      mem_o.wvalid   <= 1'b0;
      mem_o.wlast    <= 1'b0;
      mem_o.wdata    <= '0;
      mem_o.wstrb    <= '0;
      mem_o.bready   <= 1'b0;
      pkt_done_o     <= 1'b0;
      pkt_size_o     <= '0;
      pkt_addr_o     <= '0;
      pkt_oversize_o <= 1'b0;
    end else begin
      pkt_done_o <= 1'b0;
      case (state)
        IDLE_S: begin
          if (wr_stb_i) begin
            cur_addr       <= addr_i & ~ADDR_WIDTH'(DATA_WIDTH_B - 1);
            pkt_addr_o     <= addr_i & ~ADDR_WIDTH'(DATA_WIDTH_B - 1);
            beat_cnt       <= '0;
            buf_cnt        <= '0;
            got_last       <= 1'b0;
            pkt_size_o     <= '0;
            pkt_oversize_o <= 1'b0;
            state          <= FILL_S;
          end
        end
        FILL_S: begin
          if (t_hs) begin
            buf_cnt <= buf_cnt_nxt;
            if (store_beat) begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end else begin
              pkt_oversize_o <= 1'b1;
            end
            if (pkt_i.tlast) begin
              got_last   <= 1'b1;
              pkt_size_o <= store_beat ? last_size : MAX_PKT_SIZE_WIDTH'(MAX_PKT_SIZE_B);
            end
            // tlast with nothing buffered (oversize tail) finishes without a burst.
            if (pkt_i.tlast && (buf_cnt_nxt == CNT_W'(0))) begin
              pkt_done_o <= 1'b1;
              state      <= IDLE_S;
            end else if (pkt_i.tlast || (buf_cnt_nxt == CNT_W'(BURST_LEN))) begin
              mem_o.awvalid <= 1'b1;
              mem_o.awaddr  <= cur_addr;
              mem_o.awlen   <= 8'(buf_cnt_nxt - CNT_W'(1));
              state         <= AW_S;
            end
          end
        end
        AW_S: begin
          if (mem_o.awready) begin
            mem_o.awvalid <= 1'b0;
            mem_o.wvalid  <= 1'b1;
            mem_o.wdata   <= data_mem[0];
`ifdef AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
            mem_o.wstrb   <= keep_mem[0];
`else
            mem_o.wstrb   <= '1;
`endif
            mem_o.wlast   <= (buf_cnt == CNT_W'(1));
            rd_cnt        <= CNT_W'(1);
            state         <= W_S;
          end
        end
        W_S: begin
          if (mem_o.wvalid && mem_o.wready) begin
            if (mem_o.wlast) begin
              mem_o.wvalid <= 1'b0;
              mem_o.wlast  <= 1'b0;
              mem_o.bready <= 1'b1;
              state        <= B_S;
            end else begin
              mem_o.wdata <= data_mem[rd_cnt[PTR_W-1:0]];
`ifdef AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
              mem_o.wstrb <= keep_mem[rd_cnt[PTR_W-1:0]];
`else
              mem_o.wstrb <= '1;
`endif
              mem_o.wlast <= (rd_cnt == (buf_cnt - CNT_W'(1)));
              rd_cnt      <= rd_cnt + CNT_W'(1);
            end
          end
        end
        B_S: begin
          if (mem_o.bvalid) begin
            mem_o.bready <= 1'b0;
            cur_addr     <= cur_addr + ADDR_WIDTH'(buf_cnt) * ADDR_WIDTH'(DATA_WIDTH_B);
            buf_cnt      <= '0;
            if (got_last) begin
              pkt_done_o <= 1'b1;
              state      <= IDLE_S;
            end else begin
              state <= FILL_S;
            end
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// tb/tb_axi4_stream_to_axi4.sv - randomized self-checking bench for axi4_stream_to_axi4
`timescale 1ns/1ps
module tb_axi4_stream_to_axi4;
  localparam int DW        = 64;
  localparam int AW        = 32;
  localparam int BL        = 16;
  localparam int MAXB      = 2048;
  localparam int SW        = $clog2(MAXB * 4);
  localparam int DWB       = DW / 8;
  localparam int MAX_BEATS = MAXB / DWB;

  logic          clk_i    = 1'b0;
  logic          rst_i    = 1'b1;
  logic [AW-1:0] addr_i   = '0;
  logic          wr_stb_i = 1'b0;
  logic          busy_o;
  logic          pkt_done_o;
  logic [SW-1:0] pkt_size_o;
  logic [AW-1:0] pkt_addr_o;
  logic          pkt_oversize_o;

  axi4_stream_if #(.DATA_WIDTH(DW)) s_if();
  axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .AWUSER_WIDTH(1),
            .WUSER_WIDTH(1), .ARUSER_WIDTH(1)) m_if();

  axi4_stream_to_axi4 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(1), .AWUSER_WIDTH(1), .WUSER_WIDTH(1),
    .ARUSER_WIDTH(1), .BURST_LEN(BL), .MAX_PKT_SIZE_B(MAXB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_stb_i(wr_stb_i),
    .busy_o(busy_o), .pkt_done_o(pkt_done_o), .pkt_size_o(pkt_size_o),
    .pkt_addr_o(pkt_addr_o), .pkt_oversize_o(pkt_oversize_o),
    .pkt_i(s_if), .mem_o(m_if)
  );

  always #5 clk_i = ~clk_i;

  assign m_if.bid     = '0;
  assign m_if.bresp   = 2'b00;
  assign m_if.arready = 1'b0;
  assign m_if.rid     = '0;
  assign m_if.rdata   = '0;
  assign m_if.rresp   = 2'b00;
  assign m_if.rlast   = 1'b0;
  assign m_if.rvalid  = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [63:0] w_data_q[$];
  logic [7:0]  w_strb_q[$];
  bit          w_last_q[$];
  logic [63:0] exp_data[$];
  logic [2:0]  aw_size_last;
  logic [1:0]  aw_burst_last;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_b_cyc = 0, overlap_err = 0;
  int b_owed = 0, aw_wait = 0, b_wait = 0;
  int aw_delay = 0, w_mode = 0, b_delay = 0;
  bit aw_hs = 0, b_hs = 0;

  // Observe handshakes mid-cycle, where valid/ready are stable until the next edge.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (m_if.awvalid && m_if.awready) begin
        aw_addr_q.push_back(m_if.awaddr);
        aw_len_q.push_back(m_if.awlen);
        aw_size_last  = m_if.awsize;
        aw_burst_last = m_if.awburst;
        aw_hs = 1;
      end
      if (m_if.wvalid && m_if.wready) begin
        w_data_q.push_back(m_if.wdata);
        w_strb_q.push_back(m_if.wstrb);
        w_last_q.push_back(m_if.wlast);
        if (m_if.wlast) b_owed++;
      end
      if (m_if.bvalid && m_if.bready) begin
        b_hs = 1;
        last_b_cyc = cyc;
      end
      if (pkt_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (s_if.tready && (m_if.awvalid || m_if.wvalid || m_if.bready)) overlap_err++;
    end
  end

  // Memory slave with configurable AW delay, W backpressure pattern and B delay.
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      m_if.awready = 1'b0;
      m_if.wready  = 1'b0;
      m_if.bvalid  = 1'b0;
      aw_wait = 0; b_wait = 0; b_owed = 0; aw_hs = 0; b_hs = 0;
    end else begin
      if (aw_hs) begin aw_hs = 0; aw_wait = 0; end
      if (m_if.awvalid) aw_wait++;
      m_if.awready = m_if.awvalid && (aw_wait > aw_delay);
      case (w_mode)
        0: m_if.wready = 1'b1;
        1: m_if.wready = ~m_if.wready;
        2: m_if.wready = 1'($urandom_range(0, 1));
        default: m_if.wready = 1'b0;
      endcase
      if (b_hs) begin b_hs = 0; m_if.bvalid = 1'b0; end
      if (!m_if.bvalid && b_owed > 0) begin
        if (b_wait >= b_delay) begin
          m_if.bvalid = 1'b1; b_owed--; b_wait = 0;
        end else begin
          b_wait++;
        end
      end
    end
  end

  task automatic arm(input logic [31:0] addr);
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    done_cnt = 0; overlap_err = 0; done_cyc = 0; last_b_cyc = 0;
    @(posedge clk_i); #1;
    addr_i = addr; wr_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] last_keep, input bit gaps, input bit with_last);
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      int guard;
      logic [63:0] d;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        s_if.tvalid = 1'b0;
        @(posedge clk_i); #1;
      end
      d = {$urandom, $urandom};
      exp_data.push_back(d);
      s_if.tdata  = d;
      s_if.tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      s_if.tlast  = with_last && (i == n - 1);
      s_if.tvalid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk_i);
        guard++;
      end while (!s_if.tready && guard < 2000);
      if (!s_if.tready) begin
        check("tready_timeout", 64'(s_if.tready), 64'(1));
        s_if.tvalid = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_cnt == 0 && guard < 6000) begin
      @(negedge clk_i);
      guard++;
    end
    check("done_timeout", 64'(done_cnt != 0), 64'(1));
    repeat (5) @(negedge clk_i);
  endtask

  // Reference: bursts tile the stored beats in BL-sized chunks from the aligned base.
  task automatic verify(input logic [31:0] addr, input int n, input logic [7:0] last_keep);
    int stored;
    int nb;
    int exp_size;
    logic [31:0] base;
    stored = (n > MAX_BEATS) ? MAX_BEATS : n;
    nb     = (stored + BL - 1) / BL;
    base   = addr & ~32'h7;
    check("aw_count", 64'(aw_addr_q.size()), 64'(nb));
    for (int b = 0; b < nb && b < aw_addr_q.size(); b++) begin
      int len;
      len = ((stored - b * BL) >= BL) ? BL : (stored - b * BL);
      check("awaddr", 64'(aw_addr_q[b]), 64'(base + 32'(b * BL * DWB)));
      check("awlen", 64'(aw_len_q[b]), 64'(len - 1));
    end
    if (aw_addr_q.size() > 0) begin
      check("awsize", 64'(aw_size_last), 64'(3));
      check("awburst", 64'(aw_burst_last), 64'(1));
    end
    check("w_count", 64'(w_data_q.size()), 64'(stored));
    for (int i = 0; i < stored && i < w_data_q.size(); i++) begin
      logic [7:0] ek;
      ek = 8'hFF;
`ifdef AXI4_STREAM_TO_AXI4_WSTRB_FROM_TKEEP_EN
      if (i == n - 1) ek = last_keep;
`endif
      check("wdata", w_data_q[i], exp_data[i]);
      check("wstrb", 64'(w_strb_q[i]), 64'(ek));
      check("wlast", 64'(w_last_q[i]), 64'(((i % BL) == BL - 1) || (i == stored - 1)));
    end
    exp_size = (n > MAX_BEATS) ? MAXB : (n - 1) * DWB + $countones(last_keep);
    check("pkt_size", 64'(pkt_size_o), 64'(exp_size));
    check("pkt_addr", 64'(pkt_addr_o), 64'(base));
    check("pkt_oversize", 64'(pkt_oversize_o), 64'(n > MAX_BEATS));
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("busy_after_done", 64'(busy_o), 64'(0));
    check("tready_overlap", 64'(overlap_err), 64'(0));
    if (n <= MAX_BEATS) check("done_latency", 64'(done_cyc - last_b_cyc), 64'(1));
  endtask

  task automatic check_reset_values();
    check("rst_tready", 64'(s_if.tready), 64'(0));
    check("rst_awvalid", 64'(m_if.awvalid), 64'(0));
    check("rst_wvalid", 64'(m_if.wvalid), 64'(0));
    check("rst_wlast", 64'(m_if.wlast), 64'(0));
    check("rst_bready", 64'(m_if.bready), 64'(0));
    check("rst_awaddr", 64'(m_if.awaddr), 64'(0));
    check("rst_awlen", 64'(m_if.awlen), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(pkt_done_o), 64'(0));
    check("rst_size", 64'(pkt_size_o), 64'(0));
    check("rst_addr", 64'(pkt_addr_o), 64'(0));
    check("rst_oversize", 64'(pkt_oversize_o), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values();
    rst_i = 1'b0;

    aw_delay = 0; w_mode = 0; b_delay = 0;
    arm(32'h1003); send(10, 8'h0F, 0, 1); wait_done(); verify(32'h1003, 10, 8'h0F);
    arm(32'h1000); send(40, 8'hFF, 0, 1); wait_done(); verify(32'h1000, 40, 8'hFF);
    arm(32'h2000); send(16, 8'hFF, 0, 1); wait_done(); verify(32'h2000, 16, 8'hFF);

    aw_delay = 5; w_mode = 1; b_delay = 3;
    arm(32'h3000); send(23, 8'h3F, 1, 1); wait_done(); verify(32'h3000, 23, 8'h3F);

    aw_delay = 0; w_mode = 0; b_delay = 0;
    arm(32'h5000); send(5, 8'h03, 0, 1); wait_done(); verify(32'h5000, 5, 8'h03);
    arm(32'h8000); send(300, 8'h07, 0, 1); wait_done(); verify(32'h8000, 300, 8'h07);

    // Reset while a burst is stalled in the data phase.
    w_mode = 3;
    arm(32'h4000); send(16, 8'hFF, 0, 0);
    guard = 0;
    while (!m_if.wvalid && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check("reach_w_phase", 64'(m_if.wvalid), 64'(1));
    #2 rst_i = 1'b1;
    #1 check_reset_values();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    w_mode = 0;
    arm(32'h1003); send(10, 8'h0F, 0, 1); wait_done(); verify(32'h1003, 10, 8'h0F);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      int n;
      logic [7:0] kp;
      a  = $urandom & 32'hFFFF_FF80;
      n  = int'($urandom_range(1, 70));
      kp = 8'($urandom_range(1, 255));
      aw_delay = int'($urandom_range(0, 4));
      w_mode   = int'($urandom_range(0, 2));
      b_delay  = int'($urandom_range(0, 4));
      arm(a); send(n, kp, 1, 1); wait_done(); verify(a, n, kp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
